// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
// Instruction-memory request/response bundle between the fetch stage and
// instruction memory.
//
// Signals:
//   req    fetch request valid (driven by the fetch stage)
//   addr   fetch address (driven by the fetch stage)
//   rdata  instruction word, meaningful when ready=1 (driven by memory)
//   ready  memory completes the request this cycle (driven by memory)
//
// Modports:
//   master  fetch-stage side
//   slave   memory side
// ---------------------------------------------------------------------------
interface fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        ready;

    modport master (output req, output addr, input rdata, input ready);
    modport slave  (input req, input addr, output rdata, output ready);
endinterface

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage of the five-stage MIPS pipeline. Owns the F-stage
// PC, issues ready-based instruction-memory requests and produces the F/D
// pipeline register. A word that arrives while the hazard unit stalls is
// parked in a hold buffer so the same address is never fetched twice.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous, active-high reset
//   npc         next PC from the next-PC calculator
//   stall       hazard-unit stall, freezes PC and the D register
//   flush_d     turn the instruction entering (or sitting in) D into a bubble
//   im          instruction-memory bundle (master side)
//   pc          current F-stage PC (also the fetch address)
//   pc8_f       pc + 8
//   instr_d     D-stage instruction
//   pc8_d       D-stage PC + 8
//   valid_d     D-stage holds a real instruction
//   exc_d       D-stage exception code (only with ADEL_CHECK_EN)
//   fetch_busy  no instruction available this cycle
//
// Optional feature macro: ADEL_CHECK_EN
//   Enables the fetch-address check against IM_BASE/IM_LIMIT and word
//   alignment; a failing fetch is not sent to memory and delivers a NOP
//   tagged with AdEL (5'd4) into D. The IM_BASE/IM_LIMIT parameters and the
//   exc_d port exist only when the macro is defined.
// ---------------------------------------------------------------------------
module fetch_unit #(
`ifdef ADEL_CHECK_EN
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter logic [31:0] IM_LIMIT = 32'h0000_6ffc,
`endif
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  npc,
    input  logic         stall,
    input  logic         flush_d,
    fetch_unit_if.master im,
    output logic [31:0]  pc,
    output logic [31:0]  pc8_f,
    output logic [31:0]  instr_d,
    output logic [31:0]  pc8_d,
    output logic         valid_d,
`ifdef ADEL_CHECK_EN
    output logic [4:0]   exc_d,
`endif
    output logic         fetch_busy
);

    // FETCH: a request for pc is outstanding.
    // HOLD:  the word for pc has arrived and is parked in holdBuf_q.
    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetchState_t;

    fetchState_t state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] holdBuf_q, holdBuf_d;
    logic [31:0] instrD_q, instrD_d;
    logic [31:0] pc8D_q, pc8D_d;
    logic        validD_q, validD_d;
`ifdef ADEL_CHECK_EN
    logic [4:0]  excD_q, excD_d;
`endif

    logic        fetchErr;
    logic        avail;
    logic        loadD;
    logic [31:0] instrSel;
    logic [31:0] pcPlus8;

    // Decide whether an instruction word is available this cycle and where it
    // comes from. An illegal fetch address counts as available: it produces a
    // NOP instead of a memory request so the exception can travel down the pipe.
    always_comb begin
        fetchErr = 1'b0;
`ifdef ADEL_CHECK_EN
        fetchErr = (pc_q[1:0] != 2'b00) || (pc_q < IM_BASE) || (pc_q > IM_LIMIT);
`endif
        pcPlus8  = pc_q + 32'd8;
        avail    = fetchErr || (state_q == HOLD) || im.ready;
        loadD    = avail && !stall;
        if (fetchErr) begin
            instrSel = 32'h0000_0000;
        end else if (state_q == HOLD) begin
            instrSel = holdBuf_q;
        end else begin
            instrSel = im.rdata;
        end
    end

    // Memory-side and combinational outputs. The request drops during reset
    // so a response that lands in the reset cycle is simply discarded.
    always_comb begin
        im.req     = (state_q == FETCH) && !reset && !fetchErr;
        im.addr    = pc_q;
        pc         = pc_q;
        pc8_f      = pcPlus8;
        fetch_busy = !avail;
        instr_d    = instrD_q;
        pc8_d      = pc8D_q;
        valid_d    = validD_q;
`ifdef ADEL_CHECK_EN
        exc_d      = excD_q;
`endif
    end

    // Next-state logic. D deliberately holds while fetch_busy is high so a
    // branch in D stays visible to the next-PC calculator until its delay slot
    // arrives. A word that shows up during a stall is parked in the hold buffer
    // rather than refetched. The flush only rewrites D; pc, the FSM and the
    // hold buffer advance exactly as they would without it.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        holdBuf_d = holdBuf_q;
        instrD_d  = instrD_q;
        pc8D_d    = pc8D_q;
        validD_d  = validD_q;
`ifdef ADEL_CHECK_EN
        excD_d    = excD_q;
`endif
        if (loadD) begin
            pc_d     = npc;
            state_d  = FETCH;
            instrD_d = instrSel;
            pc8D_d   = pcPlus8;
            validD_d = 1'b1;
`ifdef ADEL_CHECK_EN
            excD_d   = fetchErr ? 5'd4 : 5'd0;
`endif
        end else if (avail && (state_q == FETCH)) begin
            holdBuf_d = im.rdata;
            state_d   = HOLD;
        end
        if (flush_d) begin
            instrD_d = 32'h0000_0000;
            pc8D_d   = pcPlus8;
            validD_d = 1'b0;
`ifdef ADEL_CHECK_EN
            excD_d   = 5'd0;
`endif
        end
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            holdBuf_q <= 32'h0000_0000;
            instrD_q  <= 32'h0000_0000;
            pc8D_q    <= 32'h0000_0000;
            validD_q  <= 1'b0;
`ifdef ADEL_CHECK_EN
            excD_q    <= 5'd0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            holdBuf_q <= holdBuf_d;
            instrD_q  <= instrD_d;
            pc8D_q    <= pc8D_d;
            validD_q  <= validD_d;
`ifdef ADEL_CHECK_EN
            excD_q    <= excD_d;
`endif
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit. Memory returns the address as the data
// word when ready, and random garbage otherwise. A behavioural model tracks
// the PC, whether the word for the current PC has already been received, and
// the D-stage contents.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic        clk;
    logic        reset;
    logic [31:0] npc;
    logic        stall;
    logic        flush_d;
    logic [31:0] pc;
    logic [31:0] pc8_f;
    logic [31:0] instr_d;
    logic [31:0] pc8_d;
    logic        valid_d;
    logic        fetch_busy;
`ifdef ADEL_CHECK_EN
    logic [4:0]  exc_d;
`endif

    fetch_unit_if imIf ();

    fetch_unit dut (
        .clk        (clk),
        .reset      (reset),
        .npc        (npc),
        .stall      (stall),
        .flush_d    (flush_d),
        .im         (imIf),
        .pc         (pc),
        .pc8_f      (pc8_f),
        .instr_d    (instr_d),
        .pc8_d      (pc8_d),
        .valid_d    (valid_d),
`ifdef ADEL_CHECK_EN
        .exc_d      (exc_d),
`endif
        .fetch_busy (fetch_busy)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checkCount = 0;
    int errorCount = 0;

    // Reference model state.
    bit          mKnown = 1'b0;
    logic [31:0] mPc;
    bit          mHaveWord;
    logic [31:0] mWord;
    logic [31:0] mInstrD;
    logic [31:0] mPc8D;
    logic        mValidD;
    logic [4:0]  mExcD;

    // Counts one comparison and reports it when the values differ.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // Fetch-address legality as the model sees it.
    function automatic bit modelFetchErr();
`ifdef ADEL_CHECK_EN
        return (mPc[1:0] != 2'b00) || (mPc < 32'h0000_3000) || (mPc > 32'h0000_6ffc);
`else
        return 1'b0;
`endif
    endfunction

    // One clock cycle: check registered outputs, drive inputs, check the
    // combinational outputs, then advance the model across the rising edge.
    task automatic applyStimulus(input bit rstV, input bit stallV, input bit flushV,
                                 input bit readyV, input bit takeBranch,
                                 input logic [31:0] target);
        logic [31:0] rdataV;
        logic [31:0] word;
        logic [31:0] oldPc;
        bit          err;
        bit          wordAvail;
        @(negedge clk);
        if (mKnown) begin
            checkOutput("pc", pc, mPc);
            checkOutput("instr_d", instr_d, mInstrD);
            checkOutput("pc8_d", pc8_d, mPc8D);
            checkOutput("valid_d", {31'd0, valid_d}, {31'd0, mValidD});
`ifdef ADEL_CHECK_EN
            checkOutput("exc_d", {27'd0, exc_d}, {27'd0, mExcD});
`endif
        end
        rdataV       = readyV ? mPc : $urandom;
        reset        = rstV;
        stall        = stallV;
        flush_d      = flushV;
        imIf.ready   = readyV;
        imIf.rdata   = rdataV;
        npc          = takeBranch ? target : mPc + 32'd4;
        #1;
        err       = modelFetchErr();
        wordAvail = err || mHaveWord || readyV;
        word      = err ? 32'h0 : (mHaveWord ? mWord : rdataV);
        if (mKnown) begin
            checkOutput("im_req", {31'd0, imIf.req}, {31'd0, (!rstV && !mHaveWord && !err)});
            checkOutput("im_addr", imIf.addr, mPc);
            checkOutput("fetch_busy", {31'd0, fetch_busy}, {31'd0, !wordAvail});
            checkOutput("pc8_f", pc8_f, mPc + 32'd8);
        end
        @(posedge clk);
        if (rstV) begin
            mKnown    = 1'b1;
            mPc       = RESET_PC;
            mHaveWord = 1'b0;
            mWord     = 32'h0;
            mInstrD   = 32'h0;
            mPc8D     = 32'h0;
            mValidD   = 1'b0;
            mExcD     = 5'd0;
        end else if (mKnown) begin
            oldPc = mPc;
            if (wordAvail && !stallV) begin
                mInstrD   = word;
                mPc8D     = oldPc + 32'd8;
                mValidD   = 1'b1;
                mExcD     = err ? 5'd4 : 5'd0;
                mPc       = npc;
                mHaveWord = 1'b0;
            end else if (wordAvail && !mHaveWord) begin
                mHaveWord = 1'b1;
                mWord     = rdataV;
            end
            if (flushV) begin
                mInstrD = 32'h0;
                mPc8D   = oldPc + 32'd8;
                mValidD = 1'b0;
                mExcD   = 5'd0;
            end
        end
    endtask

    initial begin
        reset      = 1'b0;
        stall      = 1'b0;
        flush_d    = 1'b0;
        npc        = 32'h0;
        imIf.ready = 1'b0;
        imIf.rdata = 32'h0;

        // Reset and zero-wait streaming.
        applyStimulus(1, 0, 0, 1, 0, 32'h0);
        applyStimulus(1, 0, 0, 1, 0, 32'h0);
        #2;
        checkOutput("rstPc", pc, 32'h0000_3000);
        checkOutput("rstValid", {31'd0, valid_d}, 32'd0);
        applyStimulus(0, 0, 0, 1, 0, 32'h0);
        #2;
        checkOutput("firstInstr", instr_d, 32'h0000_3000);
        checkOutput("firstPc8", pc8_d, 32'h0000_3008);
        checkOutput("firstPc", pc, 32'h0000_3004);

        // Three wait cycles at 0x3004.
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 32'h0);
        applyStimulus(0, 0, 0, 1, 0, 32'h0);
        #2;
        checkOutput("waitInstr", instr_d, 32'h0000_3004);
        checkOutput("waitPc8", pc8_d, 32'h0000_300c);

        // Word arrives during a stall held two cycles, then released.
        applyStimulus(0, 1, 0, 1, 0, 32'h0);
        applyStimulus(0, 1, 0, 0, 0, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        #2;
        checkOutput("holdInstr", instr_d, 32'h0000_3008);
        checkOutput("holdPc", pc, 32'h0000_300c);

        // Branch in D, delay slot takes two wait cycles.
        applyStimulus(0, 0, 0, 1, 0, 32'h0);
        applyStimulus(0, 0, 0, 0, 1, 32'h0000_3100);
        applyStimulus(0, 0, 0, 0, 1, 32'h0000_3100);
        applyStimulus(0, 0, 0, 1, 1, 32'h0000_3100);
        #2;
        checkOutput("branchPc", pc, 32'h0000_3100);
        checkOutput("slotInstr", instr_d, 32'h0000_3010);

        // Flush while loading, then flush while stalled.
        applyStimulus(0, 0, 1, 1, 0, 32'h0);
        #2;
        checkOutput("flushValid", {31'd0, valid_d}, 32'd0);
        checkOutput("flushPc", pc, 32'h0000_3104);
        applyStimulus(0, 0, 0, 1, 0, 32'h0);
        applyStimulus(0, 1, 1, 1, 0, 32'h0);
        #2;
        checkOutput("flushStallPc", pc, 32'h0000_3108);
        checkOutput("flushStallInstr", instr_d, 32'h0);

        // Reset while a fetch is waiting and its response lands in the reset cycle.
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        applyStimulus(1, 0, 0, 1, 0, 32'h0);
        #2;
        checkOutput("midRstPc", pc, 32'h0000_3000);
        checkOutput("midRstValid", {31'd0, valid_d}, 32'd0);

`ifdef ADEL_CHECK_EN
        // Misaligned fetch address produces an AdEL NOP without a request.
        applyStimulus(0, 0, 0, 1, 1, 32'h0000_3002);
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        #2;
        checkOutput("adelExc", {27'd0, exc_d}, 32'd4);
        checkOutput("adelInstr", instr_d, 32'h0);
`endif

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            bit          rstR;
            bit          brR;
            logic [31:0] tgt;
            rstR = ($urandom_range(0, 63) == 0);
            brR  = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 15) == 0) tgt = $urandom;
            else tgt = {16'h0, 14'($urandom_range(32'h0c00, 32'h1bff)), 2'b00};
            applyStimulus(rstR, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 2) != 0), brR, tgt);
        end
        applyStimulus(0, 0, 0, 1, 0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the P6 five-stage MIPS pipeline.
- Owns the F-stage PC register, which feeds the next-PC calculator's PC input and the instruction-memory address.
- Drives a ready-based instruction-memory request and produces the F/D pipeline register (instr_d, pc8_d, valid_d), which decode and the next-PC calculator consume.
- Supports a memory that may take zero or more wait cycles. It holds a fetched instruction across hazard stalls so the same address is never fetched twice.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- IM_BASE, 32'h0000_3000, lowest legal fetch address (used only with ADEL_CHECK_EN).
- IM_LIMIT, 32'h0000_6ffc, highest legal fetch address (used only with ADEL_CHECK_EN).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- npc  in  32  next PC from the next-PC calculator, combinational from pc and D-stage state.
- stall  in  1  hazard-unit stall; freezes PC and the D register.
- flush_d  in  1  kill the instruction entering D, or clear D if D is holding.
- im_req  out  1  fetch request valid.
- im_addr  out  32  fetch address, always equal to pc.
- im_rdata  in  32  instruction word, valid when im_ready=1.
- im_ready  in  1  memory completes the request this cycle; may be high in the same cycle as im_req.
- pc  out  32  current F-stage PC.
- pc8_f  out  32  pc+8, for F-stage link computation.
- instr_d  out  32  D-stage instruction.
- pc8_d  out  32  D-stage PC+8.
- valid_d  out  1  D-stage holds a real instruction.
- fetch_busy  out  1  no instruction available this cycle; hazard unit treats it as a stall and inserts an E bubble.
- exc_d  out  5  D-stage exception code; present only with ADEL_CHECK_EN.

Behaviour:
- State machine has two states: FETCH (request outstanding) and HOLD (instruction buffered in hold_buf).
- avail = (state==FETCH && im_ready) || state==HOLD.
- Instruction source is hold_buf in HOLD and im_rdata in FETCH.
- im_req = (state==FETCH) && !reset.
- im_addr = pc.
- fetch_busy = !avail.
- pc8_f = pc + 8, modulo 2^32.
- Reset (highest priority, synchronous):
  - pc <= RESET_PC, state <= FETCH, hold_buf <= 0.
  - instr_d <= 0, pc8_d <= 0, valid_d <= 0, exc_d <= 0.
  - im_ready during the reset cycle is ignored; an outstanding response is dropped.
- When avail && !stall:
  - pc <= npc.
  - D <= {instr, pc+8, valid=1}.
  - state <= FETCH.
  - The new request for npc starts in the next cycle.
- When avail && stall:
  - pc holds and D holds.
  - If in FETCH: hold_buf <= im_rdata and state <= HOLD.
  - If in HOLD: no change.
- When !avail (FETCH waiting): pc holds, D holds, state stays FETCH, im_req stays 1, im_addr is stable.
- D holding while fetch_busy is required: it keeps the branch in D visible to the next-PC calculator until its delay slot is fetched, so npc stays correct.
- flush_d:
  - If D would load: D <= bubble (instr_d=0, valid_d=0, pc8_d=pc+8) while pc still advances to npc.
  - If D would hold: D <= bubble.
  - flush_d never affects pc, the FSM, or hold_buf.
- A stall and an im_ready in the same cycle never lose the word: it is captured into hold_buf.
- A zero-wait memory (im_ready tied to 1) gives one instruction per cycle; latency from pc to instr_d is 1 cycle.
- All outputs are registered except im_req, im_addr (=pc), fetch_busy and pc8_f.

Optional Feature:
- Macro: ADEL_CHECK_EN.
- When defined:
  - A fetch address error is raised if pc[1:0]!=0, pc<IM_BASE, or pc>IM_LIMIT.
  - In that case im_req=0 and avail is forced to 1 with instr=0.
  - On load, D gets instr_d=0, valid_d=1, exc_d=5'd4 (AdEL).
  - Otherwise exc_d loads 0. flush_d and reset clear exc_d.
- When undefined:
  - The exc_d port and the range check are absent.
  - Any pc is requested unchanged.

Test Plan:
1. Reset, im_ready tied 1, npc=pc+4, memory returns address as data → pc=0x3000,0x3004,0x3008; instr_d=0x3000 with pc8_d=0x3008 one cycle later; fetch_busy=0 throughout.
2. im_ready low for 3 cycles at pc=0x3004 → im_addr stays 0x3004; fetch_busy=1 for 3 cycles; D unchanged; on ready, instr_d=word(0x3004) and pc8_d=0x300c.
3. stall=1 in the cycle im_ready returns 0x1234_5678 at pc=0x3008, stall held 2 cycles → im_req=0 during HOLD with no refetch; after release, instr_d=0x1234_5678 and pc=npc.
4. Branch in D, npc=0x3100, delay-slot fetch takes 2 wait cycles → D keeps the branch until the delay slot arrives; the next pc=0x3100.
5. flush_d=1 with avail and !stall at pc=0x3010 → valid_d=0, instr_d=0, pc=npc; with stall=1 instead → D cleared and pc held.
6. Reset asserted while waiting (im_ready arrives in the reset cycle) → pc=0x3000, state FETCH, valid_d=0; with ADEL_CHECK_EN, npc=0x3002 → exc_d=4, instr_d=0, im_req=0.
